mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multicycle control FSM for the MIPS core, including the half-word and byte load path (`half`, `b`), `bne` (`ne`) and zero-extended immediates.
- Decodes `op`/`funct` from the instruction register.
- Sequences one shared instruction/data memory through a `mem_req`/`mem_ready` handshake.
- Drives every datapath select and strobe from a Moore state machine, plus a registered `illegal` flag.
- Sits between the instruction register and the multicycle datapath, replacing the single-cycle combinational decoder.

## Interface
Parameters:
- `ALU_W`, default 3, width of `alucontrol`.

Ports (name, direction, width, meaning):
- `clk`, in, 1, rising-edge clock.
- `reset`, in, 1, asynchronous, active-low.
- `op`, in, 6, instruction [31:26] from the instruction register.
- `funct`, in, 6, instruction [5:0].
- `zero`, in, 1, ALU zero flag.
- `mem_ready`, in, 1, memory completes the current access this cycle.
- `mem_req`, out, 1, memory access request.
- `iord`, out, 1, address select: 0 = PC, 1 = ALUOut.
- `memwrite`, out, 1, memory write.
- `irwrite`, out, 1, load the instruction register.
- `pcen`, out, 1, PC register enable.
- `regdst`, out, 1, write-register select.
- `memtoreg`, out, 1, write-back select.
- `regwrite`, out, 1, register file write.
- `alusrca`, out, 1, ALU A select: 0 = PC, 1 = rs.
- `alusrcb`, out, 2, ALU B select: 00 = rt, 01 = 4, 10 = immediate, 11 = immediate<<2.
- `pcsrc`, out, 2, PC source: 00 = ALU, 01 = ALUOut, 10 = jump.
- `alucontrol`, out, `ALU_W`, ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `ne`, out, 1, invert the branch condition (`bne`).
- `zeroext`, out, 1, zero-extend the immediate (drives `alusrc[1]`).
- `half`, out, 1, sign-extend a half-word load.
- `b`, out, 1, sign-extend a byte load.
- `illegal`, out, 1, unsupported opcode or funct.
- `state`, out, 4, current state encoding, for debug.

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
- RTYPEEX=6, RTYPEWB=7, BREX=8, IMMEX=9, IMMWB=10, JEX=11.
- Encodings 12–15 are unreachable and return to FETCH.

PC enable:
- `pcen` = `pcwrite` | (`branch` & (`zero` ^ `ne`)).
- `pcwrite` and `branch` are internal signals.

Per-state outputs (all signals not listed are 0):
- FETCH:
  - Outputs: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `alucontrol`=010, `pcsrc`=00.
  - `irwrite` and `pcwrite` are 1 only while `mem_ready`=1.
  - Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
- DECODE:
  - Outputs: `alusrca`=0, `alusrcb`=11, `alucontrol`=010.
  - Next state by `op`:
    - 100011 (`lw`), 101011 (`sw`), 100001 (`lh`), 100000 (`lb`) -> MEMADR.
    - 000000 -> RTYPEEX.
    - 000100 (`beq`), 000101 (`bne`) -> BREX.
    - 001000 (`addi`), 001101 (`ori`) -> IMMEX.
    - 000010 -> JEX.
    - Any other opcode -> FETCH.
- MEMADR:
  - Outputs: `alusrca`=1, `alusrcb`=10, `alucontrol`=010.
  - Next state: `sw` -> MEMWR, otherwise MEMRD.
- MEMRD: `mem_req`=1, `iord`=1; stay while `mem_ready`=0; otherwise go to MEMWB.
- MEMWB:
  - Outputs: `regwrite`=1, `memtoreg`=1, `regdst`=0.
  - `half`=1 for `lh`; `b`=1 for `lb`.
  - Next state: FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1; stay while `mem_ready`=0; otherwise go to FETCH.
- RTYPEEX:
  - Outputs: `alusrca`=1, `alusrcb`=00.
  - `alucontrol` by `funct`: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> illegal: next state FETCH, no write-back.
  - Legal funct -> RTYPEWB.
- RTYPEWB: `regwrite`=1, `regdst`=1, `memtoreg`=0; next state FETCH.
- BREX:
  - Outputs: `alusrca`=1, `alusrcb`=00, `alucontrol`=110, `pcsrc`=01, `branch`=1.
  - `ne`=1 for `bne`.
  - Next state: FETCH.
- IMMEX:
  - Outputs: `alusrca`=1, `alusrcb`=10.
  - `addi`: `alucontrol`=010, `zeroext`=0.
  - `ori`: `alucontrol`=001, `zeroext`=1.
  - Next state: IMMWB.
- IMMWB:
  - Outputs: `regwrite`=1, `regdst`=0, `memtoreg`=0.
  - `zeroext` holds its IMMEX value.
  - Next state: FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1; next state FETCH.

`illegal`:
- Registered.
- Set to 1 for exactly one cycle on the edge that leaves DECODE with an unknown opcode, or RTYPEEX with an unknown funct.
- Cleared on the next edge.

`op` and `funct`:
- Come from the instruction register, so they are stable from DECODE until the next FETCH completes.
- Used directly; the FSM does not latch them.

## Timing
- Reset:
  - While `reset`=0: state = FETCH and `illegal`=0.
  - Every output is forced to 0, including `mem_req`.
  - `mem_req` rises combinationally once `reset`=1.
- Cycle counts with zero wait states (`mem_ready` high in the first request cycle):

  | Instruction | Cycles |
  |---|---|
  | `lw`, `lh`, `lb` | 5 |
  | `sw` | 4 |
  | R-type | 4 |
  | `addi`, `ori` | 4 |
  | `beq`, `bne` | 3 |
  | `j` | 3 |

- Each wait cycle (`mem_ready`=0 in FETCH, MEMRD or MEMWR) adds one cycle.
- While waiting, all outputs hold their values, and `irwrite`, `pcwrite` and `regwrite` stay 0.
- All outputs except `illegal` and `state` are combinational from state, `op`, `funct`, `zero` and `mem_ready`. There is no registered output latency.
- `mem_ready` asserted outside a request state is ignored.
- Reset asserted mid-access:
  - State returns immediately to FETCH and `mem_req` drops asynchronously.
  - No write or PC update occurs on that edge.

## Configuration
Macro `MC_BYTE_HALF_EN`:
- Defined:
  - `lh` (100001) and `lb` (100000) are decoded through MEMADR, MEMRD and MEMWB with `half` or `b` asserted.
- Undefined:
  - Both opcodes are illegal: DECODE -> FETCH with an `illegal` pulse.
  - `half` and `b` are tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset and fetch:
  - Stimulus: hold `reset`=0 for 3 cycles, then release; `mem_ready`=1.
  - Required response: during reset all outputs are 0 and `state`=0; on the first edge after release `irwrite`=1 and `pcen`=1, then `state`=1.
- Load with wait states:
  - Stimulus: `lw` (op 100011) with `mem_ready` low for 2 cycles in MEMRD.
  - Required response: state sequence 0,1,2,3,3,3,4,0; `regwrite`=1 with `memtoreg`=1 only in state 4.
- Branch decisions:
  - Stimulus: `beq` with `zero`=1, then `bne` with `zero`=1.
  - Required response: in BREX, `pcen`=1 for `beq` and `pcen`=0 for `bne` (`ne`=1).
- R-type and illegal funct:
  - Stimulus: funct 100101, then funct 111111.
  - Required response: for 100101, `alucontrol`=001 and `regwrite` in RTYPEWB; for 111111, `illegal` pulses for 1 cycle, the next state is FETCH and `regwrite` is never asserted.
- Immediates and jump:
  - Stimulus: `ori`, then `j` (op 000010).
  - Required response: `ori` holds `zeroext`=1 in IMMEX and IMMWB; `j` gives `pcsrc`=10 and `pcen`=1 in JEX and completes in 3 cycles.
- Byte/half loads (`MC_BYTE_HALF_EN` defined and undefined):
  - Stimulus: `lb` and `lh` in each build.
  - Required response with the macro: `b`=1 or `half`=1 in MEMWB. Without the macro: `illegal` pulses after DECODE and there are no memory requests.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// Carries the decoded instruction fields and flags in one direction and
// every datapath select, strobe and status flag in the other.
//
// Memory handshake: mem_req is held high for the whole access. The access
// completes on the rising edge where mem_req and mem_ready are both high.
// mem_ready outside a request state has no effect.
interface mips_mc_controller_if #(
  parameter int ALU_W = 3
);
  // datapath -> controller
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;

  // controller -> datapath
  logic             mem_req;
  logic             iord;
  logic             memwrite;
  logic             irwrite;
  logic             pcen;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [ALU_W-1:0] alucontrol;
  logic             ne;
  logic             zeroext;
  logic             half;
  logic             b;
  logic             illegal;
  logic [3:0]       state;

  // Controller side
  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, alucontrol, ne, zeroext,
           half, b, illegal, state
  );

  // Datapath side
  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg,
           regwrite, alusrca, alusrcb, pcsrc, alucontrol, ne, zeroext,
           half, b, illegal, state
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM (Moore) with a shared instruction/data memory
// sequenced through mem_req/mem_ready.
// Optional feature macro: MC_BYTE_HALF_EN enables the lh/lb load path;
// without it both opcodes decode as illegal and half/b stay 0.
module mips_mc_controller #(
  parameter int ALU_W = 3
) (
  input  logic                clk,
  input  logic                reset,   // asynchronous, active-low
  mips_mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BREX    = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b110);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b111);

  state_t           r_state;
  logic             r_illegal;

  logic             w_is_lh;
  logic             w_is_lb;
  logic             w_is_mem;
  logic             w_is_sw;
  logic             w_is_bne;
  logic             w_is_ori;
  logic             w_funct_legal;
  logic [ALU_W-1:0] w_rtype_alu;
  logic             w_pcwrite;
  logic             w_branch;

`ifdef MC_BYTE_HALF_EN
  assign w_is_lh = (bus.op == 6'b100001);
  assign w_is_lb = (bus.op == 6'b100000);
`else
  assign w_is_lh = 1'b0;
  assign w_is_lb = 1'b0;
`endif

  assign w_is_sw  = (bus.op == OP_SW);
  assign w_is_mem = (bus.op == OP_LW) | w_is_sw | w_is_lh | w_is_lb;
  assign w_is_bne = (bus.op == OP_BNE);
  assign w_is_ori = (bus.op == OP_ORI);

  // R-type funct decode: ALU operation and legality
  always_comb begin
    w_funct_legal = 1'b1;
    w_rtype_alu   = '0;
    case (bus.funct)
      FN_ADD:  w_rtype_alu = ALU_ADD;
      FN_SUB:  w_rtype_alu = ALU_SUB;
      FN_AND:  w_rtype_alu = ALU_AND;
      FN_OR:   w_rtype_alu = ALU_OR;
      FN_SLT:  w_rtype_alu = ALU_SLT;
      default: w_funct_legal = 1'b0;
    endcase
  end

  // State register and one-cycle illegal pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        FETCH: begin
          if (bus.mem_ready) r_state <= DECODE;
        end
        DECODE: begin
          if (w_is_mem)                                   r_state <= MEMADR;
          else if (bus.op == OP_RTYPE)                    r_state <= RTYPEEX;
          else if ((bus.op == OP_BEQ) || w_is_bne)        r_state <= BREX;
          else if ((bus.op == OP_ADDI) || w_is_ori)       r_state <= IMMEX;
          else if (bus.op == OP_J)                        r_state <= JEX;
          else begin
            r_state   <= FETCH;
            r_illegal <= 1'b1;
          end
        end
        MEMADR:  r_state <= w_is_sw ? MEMWR : MEMRD;
        MEMRD: begin
          if (bus.mem_ready) r_state <= MEMWB;
        end
        MEMWB:   r_state <= FETCH;
        MEMWR: begin
          if (bus.mem_ready) r_state <= FETCH;
        end
        RTYPEEX: begin
          if (w_funct_legal) r_state <= RTYPEWB;
          else begin
            r_state   <= FETCH;
            r_illegal <= 1'b1;
          end
        end
        RTYPEWB: r_state <= FETCH;
        BREX:    r_state <= FETCH;
        IMMEX:   r_state <= IMMWB;
        IMMWB:   r_state <= FETCH;
        JEX:     r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Moore outputs from state (plus op/funct/zero/mem_ready), all forced low in reset
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = '0;
    bus.ne         = 1'b0;
    bus.zeroext    = 1'b0;
    bus.half       = 1'b0;
    bus.b          = 1'b0;
    w_pcwrite      = 1'b0;
    w_branch       = 1'b0;
    if (reset) begin
      case (r_state)
        FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alusrcb    = 2'b01;
          bus.alucontrol = ALU_ADD;
          bus.irwrite    = bus.mem_ready;
          w_pcwrite      = bus.mem_ready;
        end
        DECODE: begin
          bus.alusrcb    = 2'b11;
          bus.alucontrol = ALU_ADD;
        end
        MEMADR: begin
          bus.alusrca    = 1'b1;
          bus.alusrcb    = 2'b10;
          bus.alucontrol = ALU_ADD;
        end
        MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
          bus.half     = w_is_lh;
          bus.b        = w_is_lb;
        end
        MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.memwrite = 1'b1;
        end
        RTYPEEX: begin
          bus.alusrca    = 1'b1;
          bus.alucontrol = w_rtype_alu;
        end
        RTYPEWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        BREX: begin
          bus.alusrca    = 1'b1;
          bus.alucontrol = ALU_SUB;
          bus.pcsrc      = 2'b01;
          bus.ne         = w_is_bne;
          w_branch       = 1'b1;
        end
        IMMEX: begin
          bus.alusrca    = 1'b1;
          bus.alusrcb    = 2'b10;
          bus.alucontrol = w_is_ori ? ALU_OR : ALU_ADD;
          bus.zeroext    = w_is_ori;
        end
        IMMWB: begin
          // op is still held by the IR, so zeroext simply re-decodes it
          bus.regwrite = 1'b1;
          bus.zeroext  = w_is_ori;
        end
        JEX: begin
          bus.pcsrc = 2'b10;
          w_pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
    bus.pcen = w_pcwrite | (w_branch & (bus.zero ^ bus.ne));
  end

  assign bus.illegal = r_illegal;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Table-driven bench for mips_mc_controller. Each table row is one clock
// cycle: inputs applied on the falling edge, outputs compared just before
// the next rising edge. Build with +define+MC_BYTE_HALF_EN for the lh/lb path.
module tb_mips_mc_controller;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mips_mc_controller_if #(.ALU_W(3)) bus_if ();

  mips_mc_controller #(.ALU_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Clock
  always #5 clk = ~clk;

  // Control word layout:
  // 19 mem_req 18 iord 17 memwrite 16 irwrite 15 pcen 14 regdst 13 memtoreg
  // 12 regwrite 11 alusrca 10:9 alusrcb 8:7 pcsrc 6:4 alucontrol 3 ne
  // 2 zeroext 1 half 0 b
  localparam logic [19:0] MEMREQ  = 20'h80000;
  localparam logic [19:0] IORD    = 20'h40000;
  localparam logic [19:0] MEMW    = 20'h20000;
  localparam logic [19:0] IRW     = 20'h10000;
  localparam logic [19:0] PCEN    = 20'h08000;
  localparam logic [19:0] REGDST  = 20'h04000;
  localparam logic [19:0] M2R     = 20'h02000;
  localparam logic [19:0] REGW    = 20'h01000;
  localparam logic [19:0] SRCA    = 20'h00800;
  localparam logic [19:0] SB_4    = 20'h00200;
  localparam logic [19:0] SB_IMM  = 20'h00400;
  localparam logic [19:0] SB_SH   = 20'h00600;
  localparam logic [19:0] PS_OUT  = 20'h00080;
  localparam logic [19:0] PS_J    = 20'h00100;
  localparam logic [19:0] ALU_ADD = 20'h00020;
  localparam logic [19:0] ALU_SUB = 20'h00060;
  localparam logic [19:0] ALU_OR  = 20'h00010;
  localparam logic [19:0] ALU_SLT = 20'h00070;
  localparam logic [19:0] NE      = 20'h00008;
  localparam logic [19:0] ZEXT    = 20'h00004;
  localparam logic [19:0] HALF    = 20'h00002;
  localparam logic [19:0] BYTE    = 20'h00001;

  // Expected words per state
  localparam logic [19:0] C_FRDY  = MEMREQ | IRW | PCEN | SB_4 | ALU_ADD;
  localparam logic [19:0] C_FWAIT = MEMREQ | SB_4 | ALU_ADD;
  localparam logic [19:0] C_DEC   = SB_SH | ALU_ADD;
  localparam logic [19:0] C_MADR  = SRCA | SB_IMM | ALU_ADD;
  localparam logic [19:0] C_MRD   = MEMREQ | IORD;
  localparam logic [19:0] C_MWB   = REGW | M2R;
  localparam logic [19:0] C_MWR   = MEMREQ | IORD | MEMW;
  localparam logic [19:0] C_RTWB  = REGW | REGDST;
  localparam logic [19:0] C_BR    = SRCA | ALU_SUB | PS_OUT;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic        ill;
    logic [19:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic r, input logic [5:0] op,
                              input logic [5:0] fn, input logic z,
                              input logic rdy, input logic [3:0] st,
                              input logic ill, input logic [19:0] ctl);
    vec_t v;
    v.rst_n = r;   v.op  = op;  v.funct = fn; v.zero = z;
    v.rdy   = rdy; v.st  = st;  v.ill   = ill; v.ctl = ctl;
    return v;
  endfunction

  // Row in normal operation (reset released)
  task automatic row(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [3:0] st, input logic ill,
                     input logic [19:0] ctl);
    tbl.push_back(mk(1'b1, op, fn, z, rdy, st, ill, ctl));
  endtask

  function automatic logic [19:0] act_ctl();
    return {bus_if.mem_req, bus_if.iord, bus_if.memwrite, bus_if.irwrite,
            bus_if.pcen, bus_if.regdst, bus_if.memtoreg, bus_if.regwrite,
            bus_if.alusrca, bus_if.alusrcb, bus_if.pcsrc, bus_if.alucontrol,
            bus_if.ne, bus_if.zeroext, bus_if.half, bus_if.b};
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Driver: apply one row on the falling edge, compare before the rising edge
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset            = v.rst_n;
    bus_if.op        = v.op;
    bus_if.funct     = v.funct;
    bus_if.zero      = v.zero;
    bus_if.mem_ready = v.rdy;
    #2;
    check("state",   idx, 20'(bus_if.state),   20'(v.st));
    check("illegal", idx, 20'(bus_if.illegal), 20'(v.ill));
    check("ctl",     idx, act_ctl(),           v.ctl);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.op        = OP_LW;
    bus_if.funct     = 6'd0;
    bus_if.zero      = 1'b0;
    bus_if.mem_ready = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, 1'b0, 20'h0));

    // lw with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    row(OP_LW, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_LW, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_LW, 6'd0, 0, 1, 4'd2, 0, C_MADR);
    row(OP_LW, 6'd0, 0, 0, 4'd3, 0, C_MRD);
    row(OP_LW, 6'd0, 0, 0, 4'd3, 0, C_MRD);
    row(OP_LW, 6'd0, 0, 1, 4'd3, 0, C_MRD);
    row(OP_LW, 6'd0, 0, 0, 4'd4, 0, C_MWB);

    // sw with a fetch wait and a MEMWR wait
    row(OP_SW, 6'd0, 0, 0, 4'd0, 0, C_FWAIT);
    row(OP_SW, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_SW, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_SW, 6'd0, 0, 1, 4'd2, 0, C_MADR);
    row(OP_SW, 6'd0, 0, 0, 4'd5, 0, C_MWR);
    row(OP_SW, 6'd0, 0, 1, 4'd5, 0, C_MWR);

    // Branches: beq/bne with zero high and low
    row(OP_BEQ, 6'd0, 1, 1, 4'd0, 0, C_FRDY);
    row(OP_BEQ, 6'd0, 1, 1, 4'd1, 0, C_DEC);
    row(OP_BEQ, 6'd0, 1, 1, 4'd8, 0, C_BR | PCEN);
    row(OP_BNE, 6'd0, 1, 1, 4'd0, 0, C_FRDY);
    row(OP_BNE, 6'd0, 1, 1, 4'd1, 0, C_DEC);
    row(OP_BNE, 6'd0, 1, 1, 4'd8, 0, C_BR | NE);
    row(OP_BNE, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_BNE, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_BNE, 6'd0, 0, 1, 4'd8, 0, C_BR | NE | PCEN);
    row(OP_BEQ, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_BEQ, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_BEQ, 6'd0, 0, 1, 4'd8, 0, C_BR);

    // R-type: or, sub, slt, and
    row(OP_R, 6'b100101, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_R, 6'b100101, 0, 1, 4'd1, 0, C_DEC);
    row(OP_R, 6'b100101, 0, 1, 4'd6, 0, SRCA | ALU_OR);
    row(OP_R, 6'b100101, 0, 1, 4'd7, 0, C_RTWB);
    row(OP_R, 6'b100010, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_R, 6'b100010, 0, 1, 4'd1, 0, C_DEC);
    row(OP_R, 6'b100010, 0, 1, 4'd6, 0, SRCA | ALU_SUB);
    row(OP_R, 6'b100010, 0, 1, 4'd7, 0, C_RTWB);
    row(OP_R, 6'b101010, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_R, 6'b101010, 0, 1, 4'd1, 0, C_DEC);
    row(OP_R, 6'b101010, 0, 1, 4'd6, 0, SRCA | ALU_SLT);
    row(OP_R, 6'b101010, 0, 1, 4'd7, 0, C_RTWB);
    row(OP_R, 6'b100100, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_R, 6'b100100, 0, 1, 4'd1, 0, C_DEC);
    row(OP_R, 6'b100100, 0, 1, 4'd6, 0, SRCA);
    row(OP_R, 6'b100100, 0, 1, 4'd7, 0, C_RTWB);

    // Illegal funct: back to FETCH, one-cycle illegal pulse, no write-back
    row(OP_R, 6'b111111, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_R, 6'b111111, 0, 1, 4'd1, 0, C_DEC);
    row(OP_R, 6'b111111, 0, 1, 4'd6, 0, SRCA);

    // addi (first fetch carries the illegal pulse), then ori
    row(OP_ADDI, 6'd0, 0, 1, 4'd0, 1, C_FRDY);
    row(OP_ADDI, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_ADDI, 6'd0, 0, 1, 4'd9, 0, SRCA | SB_IMM | ALU_ADD);
    row(OP_ADDI, 6'd0, 0, 1, 4'd10, 0, REGW);
    row(OP_ORI, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_ORI, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_ORI, 6'd0, 0, 1, 4'd9, 0, SRCA | SB_IMM | ALU_OR | ZEXT);
    row(OP_ORI, 6'd0, 0, 1, 4'd10, 0, REGW | ZEXT);

    // j: three cycles
    row(OP_J, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_J, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_J, 6'd0, 0, 1, 4'd11, 0, PS_J | PCEN);

    // Unknown opcode
    row(OP_BAD, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_BAD, 6'd0, 0, 1, 4'd1, 0, C_DEC);

`ifdef MC_BYTE_HALF_EN
    row(OP_LB, 6'd0, 0, 1, 4'd0, 1, C_FRDY);
    row(OP_LB, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_LB, 6'd0, 0, 1, 4'd2, 0, C_MADR);
    row(OP_LB, 6'd0, 0, 1, 4'd3, 0, C_MRD);
    row(OP_LB, 6'd0, 0, 1, 4'd4, 0, C_MWB | BYTE);
    row(OP_LH, 6'd0, 0, 1, 4'd0, 0, C_FRDY);
    row(OP_LH, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_LH, 6'd0, 0, 1, 4'd2, 0, C_MADR);
    row(OP_LH, 6'd0, 0, 1, 4'd3, 0, C_MRD);
    row(OP_LH, 6'd0, 0, 1, 4'd4, 0, C_MWB | HALF);
    row(OP_J,  6'd0, 0, 1, 4'd0, 0, C_FRDY);
`else
    row(OP_LB, 6'd0, 0, 1, 4'd0, 1, C_FRDY);
    row(OP_LB, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_LH, 6'd0, 0, 1, 4'd0, 1, C_FRDY);
    row(OP_LH, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_J,  6'd0, 0, 1, 4'd0, 1, C_FRDY);
`endif
    row(OP_J, 6'd0, 0, 1, 4'd1, 0, C_DEC);
    row(OP_J, 6'd0, 0, 1, 4'd11, 0, PS_J | PCEN);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i);

    // Reset asserted mid-access while waiting in MEMRD
    apply(mk(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, 1'b0, C_FRDY), 1000);
    apply(mk(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, 1'b0, C_DEC),  1001);
    apply(mk(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, 1'b0, C_MADR), 1002);
    apply(mk(1'b1, OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, 1'b0, C_MRD),  1003);
    #1;
    reset = 1'b0;
    bus_if.mem_ready = 1'b1;
    #1;
    check("async_reset_state", 1004, 20'(bus_if.state), 20'h0);
    check("async_reset_ctl",   1004, act_ctl(),         20'h0);
    @(posedge clk);
    #1;
    check("reset_edge_state", 1005, 20'(bus_if.state), 20'h0);
    check("reset_edge_ctl",   1005, act_ctl(),         20'h0);
    apply(mk(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, 1'b0, C_FRDY), 1006);
    apply(mk(1'b1, OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, 1'b0, C_DEC),  1007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
